// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - bus bundle between both caches, the arbiter and mem_controller
//
// Purpose: groups every request, response and return signal that crosses the arbiter.
// Modports:
//   slave  - the arbiter's view: cache requests and controller replies in, controller command
//            and per-cache replies out.
//   master - the environment's view (caches + controller together), the mirror image.
// Signals:
//   dc_command/dc_addr/dc_wdata  dcache request          ic_command/ic_addr  icache request
//   mem_response/mem_rdata/mem_tag controller replies    mem_command/mem_addr/mem_wdata  to controller
//   dc_response/ic_response      per-cache accept tag    dc_tag/ic_tag       per-cache return tag
//   rdata                        broadcast return data   err_spurious        sticky orphan-return flag

interface mem_bus_arbiter_if #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 4
);
   logic [1:0]       dc_command;
   logic [XLEN-1:0]  dc_addr;
   logic [63:0]      dc_wdata;
   logic [1:0]       ic_command;
   logic [XLEN-1:0]  ic_addr;
   logic [TAG_W-1:0] mem_response;
   logic [63:0]      mem_rdata;
   logic [TAG_W-1:0] mem_tag;

   logic [1:0]       mem_command;
   logic [XLEN-1:0]  mem_addr;
   logic [63:0]      mem_wdata;
   logic [TAG_W-1:0] dc_response;
   logic [TAG_W-1:0] ic_response;
   logic [TAG_W-1:0] dc_tag;
   logic [TAG_W-1:0] ic_tag;
   logic [63:0]      rdata;
   logic             err_spurious;

   modport slave (
      input  dc_command, dc_addr, dc_wdata, ic_command, ic_addr,
             mem_response, mem_rdata, mem_tag,
      output mem_command, mem_addr, mem_wdata, dc_response, ic_response,
             dc_tag, ic_tag, rdata, err_spurious
   );

   modport master (
      output dc_command, dc_addr, dc_wdata, ic_command, ic_addr,
             mem_response, mem_rdata, mem_tag,
      input  mem_command, mem_addr, mem_wdata, dc_response, ic_response,
             dc_tag, ic_tag, rdata, err_spurious
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares the mem_controller port between icache and dcache
//
// Purpose: grants one cache per cycle (dcache first, icache after STARVE_LIMIT consecutive
//          losses), routes the accept tag to the winner and steers returned tags to the cache
//          that owns them via a per-tag owner table.
// Ports:
//   clock   in  clock
//   reset   in  synchronous, active-high reset
//   bus     mem_bus_arbiter_if.slave - all request/response/return signals
// TAG_W must match the interface instance's TAG_W.

module mem_bus_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TAG_W        = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   mem_bus_arbiter_if.slave      bus
);
   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;

   localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
   localparam int               DEPTH   = 2 ** TAG_W;

   logic [CNT_W-1:0] starve_cnt;
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] owner_q;   // 1 = icache owns the tag
   logic             err_q;

   logic dc_req, ic_req, ic_win, dc_win, accepted, load_set, ret_hit, ret_miss;

   // Grant decision and table lookups, all same-cycle
   always_comb begin
      dc_req   = (bus.dc_command != BUS_NONE);
      ic_req   = (bus.ic_command != BUS_NONE);
      ic_win   = ic_req && (!dc_req || (starve_cnt == CNT_MAX));
      dc_win   = dc_req && !ic_win;
      accepted = (bus.mem_response != '0);
      load_set = accepted && ((ic_win && (bus.ic_command == BUS_LOAD)) ||
                              (dc_win && (bus.dc_command == BUS_LOAD)));
      ret_hit  = (bus.mem_tag != '0) &&  valid_q[bus.mem_tag];
      ret_miss = (bus.mem_tag != '0) && !valid_q[bus.mem_tag];
   end

   // Pass-through outputs
   always_comb begin
      bus.mem_command  = BUS_NONE;
      bus.mem_addr     = '0;
      bus.mem_wdata    = '0;
      bus.dc_response  = '0;
      bus.ic_response  = '0;
      bus.dc_tag       = '0;
      bus.ic_tag       = '0;
      bus.rdata        = bus.mem_rdata;
      bus.err_spurious = err_q;
      if (ic_win) begin
         bus.mem_command = bus.ic_command;
         bus.mem_addr    = bus.ic_addr;
         bus.ic_response = bus.mem_response;
      end else if (dc_win) begin
         bus.mem_command = bus.dc_command;
         bus.mem_addr    = bus.dc_addr;
         bus.mem_wdata   = bus.dc_wdata;
         bus.dc_response = bus.mem_response;
      end
      // The return reads the entry as it stands this cycle, even if it is re-set at the edge
      if (ret_hit) begin
         if (owner_q[bus.mem_tag]) bus.ic_tag = bus.mem_tag;
         else                      bus.dc_tag = bus.mem_tag;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt <= '0;
         valid_q    <= '0;
         owner_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         // A rejected icache grant counts as a loss: the icache still has to retry
         if (!ic_req || (ic_win && accepted))
            starve_cnt <= '0;
         else if (starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + CNT_W'(1);

         if (ret_hit)
            valid_q[bus.mem_tag] <= 1'b0;
         // Placed after the clear so a same-index set wins
         if (load_set) begin
            valid_q[bus.mem_response] <= 1'b1;
            owner_q[bus.mem_response] <= ic_win;
         end

         if (ret_miss)
            err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter

module tb_mem_bus_arbiter;
   localparam logic [1:0] NONE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] STORE = 2'd2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   mem_bus_arbiter_if bus ();

   mem_bus_arbiter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.dc_command = NONE; bus.dc_addr = '0; bus.dc_wdata = '0;
      bus.ic_command = NONE; bus.ic_addr = '0;
      bus.mem_response = '0; bus.mem_rdata = '0; bus.mem_tag = '0;
   endtask

   // advance one edge, then settle just after it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // drive, then let combinational outputs settle (still well before the next edge)
   task automatic settle();
      #3;
   endtask

   initial begin
      idle();
      step();
      step();
      reset = 1'b0;
      settle();
      chk("rst_mem_command", bus.mem_command, NONE);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_dc_response", bus.dc_response, 0);
      chk("rst_ic_response", bus.ic_response, 0);
      chk("rst_tags", {bus.dc_tag, bus.ic_tag}, 0);
      chk("rst_err", bus.err_spurious, 0);
      chk("rst_starve", dut.starve_cnt, 0);

      // 1: dcache load accepted with tag 3, later returned
      step();
      bus.dc_command = LOAD; bus.dc_addr = 64'h100; bus.dc_wdata = 64'hAA; bus.mem_response = 4'd3;
      settle();
      chk("t1_mem_command", bus.mem_command, LOAD);
      chk("t1_mem_addr", bus.mem_addr, 64'h100);
      chk("t1_mem_wdata", bus.mem_wdata, 64'hAA);
      chk("t1_dc_response", bus.dc_response, 3);
      chk("t1_ic_response", bus.ic_response, 0);
      step();
      idle(); bus.mem_tag = 4'd3; bus.mem_rdata = 64'h1234_5678;
      settle();
      chk("t1_dc_tag", bus.dc_tag, 3);
      chk("t1_ic_tag", bus.ic_tag, 0);
      chk("t1_rdata", bus.rdata, 64'h1234_5678);
      step();
      idle();
      settle();
      chk("t1_err", bus.err_spurious, 0);

      // 2: both request for 5 cycles; icache wins the fifth
      for (int c = 0; c < 5; c++) begin
         step();
         bus.dc_command = LOAD; bus.dc_addr = 64'h200 + 64'(c * 8); bus.dc_wdata = 64'h55;
         bus.ic_command = LOAD; bus.ic_addr = 64'h1000; bus.mem_response = 4'(c + 1);
         settle();
         chk("t2_starve", dut.starve_cnt, 64'(c));
         chk("t2_dc_response", bus.dc_response, (c < 4) ? 64'(c + 1) : 64'd0);
         chk("t2_ic_response", bus.ic_response, (c < 4) ? 64'd0 : 64'd5);
         chk("t2_mem_addr", bus.mem_addr, (c < 4) ? 64'h200 + 64'(c * 8) : 64'h1000);
         chk("t2_mem_wdata", bus.mem_wdata, (c < 4) ? 64'h55 : 64'h0);
      end
      step();
      idle();
      settle();
      chk("t2_starve_after", dut.starve_cnt, 0);

      // drain tags 1..4 (dcache) and 5 (icache)
      for (int t = 1; t <= 5; t++) begin
         step();
         idle(); bus.mem_tag = 4'(t);
         settle();
         chk("drain_dc_tag", bus.dc_tag, (t < 5) ? 64'(t) : 64'd0);
         chk("drain_ic_tag", bus.ic_tag, (t < 5) ? 64'd0 : 64'd5);
      end

      // 3: icache tag 7, dcache tag 8, returned out of order
      step();
      idle(); bus.ic_command = LOAD; bus.ic_addr = 64'h2000; bus.mem_response = 4'd7;
      settle();
      chk("t3_ic_response", bus.ic_response, 7);
      chk("t3_dc_response0", bus.dc_response, 0);
      chk("t3_mem_addr", bus.mem_addr, 64'h2000);
      step();
      idle(); bus.dc_command = LOAD; bus.dc_addr = 64'h300; bus.mem_response = 4'd8;
      settle();
      chk("t3_dc_response", bus.dc_response, 8);
      step();
      idle(); bus.mem_tag = 4'd8;
      settle();
      chk("t3_ret8", {bus.dc_tag, bus.ic_tag}, {4'd8, 4'd0});
      step();
      idle(); bus.mem_tag = 4'd7;
      settle();
      chk("t3_ret7", {bus.dc_tag, bus.ic_tag}, {4'd0, 4'd7});

      // 4: accepted store is not recorded; its tag returning is spurious
      step();
      idle(); bus.dc_command = STORE; bus.dc_addr = 64'h400; bus.dc_wdata = 64'hDEAD; bus.mem_response = 4'd2;
      settle();
      chk("t4_mem_command", bus.mem_command, STORE);
      chk("t4_mem_wdata", bus.mem_wdata, 64'hDEAD);
      chk("t4_dc_response", bus.dc_response, 2);
      step();
      idle(); bus.mem_tag = 4'd2;
      settle();
      chk("t4_tags", {bus.dc_tag, bus.ic_tag}, 0);
      chk("t4_err_before", bus.err_spurious, 0);
      step();
      idle();
      settle();
      chk("t4_err_after", bus.err_spurious, 1);

      // 5: tag 5 returns to dcache while icache load is accepted with tag 5
      step();
      idle(); bus.dc_command = LOAD; bus.dc_addr = 64'h308; bus.mem_response = 4'd5;
      settle();
      step();
      idle(); bus.ic_command = LOAD; bus.ic_addr = 64'h3000; bus.mem_response = 4'd5; bus.mem_tag = 4'd5;
      settle();
      chk("t5_same_dc_tag", bus.dc_tag, 5);
      chk("t5_same_ic_tag", bus.ic_tag, 0);
      chk("t5_ic_response", bus.ic_response, 5);
      step();
      idle(); bus.mem_tag = 4'd5;
      settle();
      chk("t5_new_owner", {bus.dc_tag, bus.ic_tag}, {4'd0, 4'd5});
      step();
      idle(); bus.mem_tag = 4'd5;
      settle();
      chk("t5_cleared", {bus.dc_tag, bus.ic_tag}, 0);

      // 6: rejected grant, then reset mid-run
      step();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      settle();
      chk("t6_err_reset", bus.err_spurious, 0);
      step();
      idle(); bus.dc_command = LOAD; bus.dc_addr = 64'h500; bus.ic_command = LOAD; bus.ic_addr = 64'h600;
      settle();
      chk("t6_dc_response0", bus.dc_response, 0);
      chk("t6_ic_response0", bus.ic_response, 0);
      chk("t6_mem_addr", bus.mem_addr, 64'h500);
      step();
      settle();
      chk("t6_no_write", dut.valid_q, 0);
      chk("t6_starve1", dut.starve_cnt, 1);
      bus.dc_addr = 64'h508; bus.mem_response = 4'd9;
      settle();
      chk("t6_dc_response9", bus.dc_response, 9);
      step();
      chk("t6_starve2", dut.starve_cnt, 2);
      idle(); bus.mem_tag = 4'd9;
      reset = 1'b1;
      step();
      settle();
      chk("t6_rst_starve", dut.starve_cnt, 0);
      chk("t6_rst_table", dut.valid_q, 0);
      chk("t6_rst_err", bus.err_spurious, 0);
      reset = 1'b0;
      settle();
      chk("t6_post_tags", {bus.dc_tag, bus.ic_tag}, 0);
      step();
      idle();
      settle();
      chk("t6_post_err", bus.err_spurious, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
